// File: rtl/pipelined_ripple_adder.sv
// pipelined_ripple_adder: WIDTH-bit ripple-carry adder split into STAGES
// equal chunks, one chunk resolved per stage, one new addition per cycle.
// Ports: clk, rst (async, active-high); in_valid/in_ready + A, B, Cin in;
// out_valid/out_ready + S, Cout out.
// Optional macro RCA_PIPE_OVF_EN adds Ovf (signed overflow, with S/Cout).
module pipelined_ripple_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout
`ifdef RCA_PIPE_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int CW = WIDTH / STAGES;
    // Stage i keeps only the B chunks still to be added: CW*(STAGES-1-i) bits.
    // All stages' B skew registers are packed into one flat vector.
    localparam int BT = CW * STAGES * (STAGES - 1) / 2;
    localparam int BW = (BT > 0) ? BT : 1;

    function automatic int boff(input int i);
        return CW * (i * STAGES - i * (i + 1) / 2);
    endfunction

    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] c_q, c_d;
    logic [WIDTH-1:0]  w_q [STAGES];
    logic [WIDTH-1:0]  w_d [STAGES];
    logic [BW-1:0]     b_q, b_d;
    logic              adv;

`ifdef RCA_PIPE_OVF_EN
    logic cmsb;
    logic ovf_q;
`endif

    assign adv = !(out_valid && !out_ready);

    // w holds finished sum chunks below the current chunk and the
    // not-yet-added A chunks above it, so one word carries both.
    for (genvar i = 0; i < STAGES; i++) begin : g_stg
        localparam int IW = CW * (STAGES - i);
        logic             vin;
        logic             cin;
        logic [WIDTH-1:0] win;
        logic [WIDTH-1:0] wn;
        logic [IW-1:0]    bin;
        logic [CW-1:0]    ach;
        logic [CW-1:0]    sch;
        logic [CW:0]      cc;

        if (i == 0) begin : g_head
            assign vin = in_valid;
            assign win = A;
            assign bin = B;
            assign cin = Cin;
        end else begin : g_body
            assign vin = v_q[i-1];
            assign win = w_q[i-1];
            assign bin = b_q[boff(i-1) +: IW];
            assign cin = c_q[i-1];
        end

        assign ach = win[i*CW +: CW];

        always_comb begin
            sch   = '0;
            cc    = '0;
            cc[0] = cin;
            for (int j = 0; j < CW; j++) begin
                sch[j]  = ach[j] ^ bin[j] ^ cc[j];
                cc[j+1] = (ach[j] & bin[j]) | (cc[j] & (ach[j] ^ bin[j]));
            end
            wn = win;
            wn[i*CW +: CW] = sch;
        end

        if (i < STAGES - 1) begin : g_skew
            assign b_d[boff(i) +: CW*(STAGES-1-i)] = bin[IW-1:CW];
        end

`ifdef RCA_PIPE_OVF_EN
        if (i == STAGES - 1) begin : g_tail
            assign cmsb = cc[CW-1];
        end
`endif

        assign v_d[i] = vin;
        assign c_d[i] = cc[CW];
        assign w_d[i] = wn;
    end

    if (BT == 0) begin : g_nob
        assign b_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            c_q <= '0;
            b_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                w_q[k] <= '0;
            end
`ifdef RCA_PIPE_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else if (adv) begin
            v_q <= v_d;
            c_q <= c_d;
            b_q <= b_d;
            w_q <= w_d;
`ifdef RCA_PIPE_OVF_EN
            ovf_q <= cmsb ^ c_d[STAGES-1];
`endif
        end
    end

    assign in_ready  = adv;
    assign out_valid = v_q[STAGES-1];
    assign S         = w_q[STAGES-1];
    assign Cout      = c_q[STAGES-1];
`ifdef RCA_PIPE_OVF_EN
    assign Ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// tb_pipelined_ripple_adder: directed checks of the 8-bit, 2-stage adder.
// Covers reset, basic sums, streaming, backpressure, mid-flight reset.
module tb_pipelined_ripple_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] A = '0;
    logic [7:0] B = '0;
    logic       Cin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] S;
    logic       Cout;
`ifdef RCA_PIPE_OVF_EN
    logic       Ovf;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] ta  [16] = '{8'h00, 8'h01, 8'h0F, 8'hF0, 8'h80, 8'hAA, 8'hAA, 8'h12,
                             8'h99, 8'hFF, 8'hFF, 8'h7F, 8'h0E, 8'hC8, 8'h5A, 8'h3C};
    logic [7:0] tb_ [16] = '{8'h00, 8'h01, 8'h01, 8'h10, 8'h7F, 8'h55, 8'h55, 8'h34,
                             8'h11, 8'hFF, 8'hFF, 8'h7F, 8'h03, 8'h64, 8'hA5, 8'h55};
    logic       tc  [16] = '{0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    logic [7:0] ts  [16] = '{8'h00, 8'h02, 8'h10, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h46,
                             8'hAA, 8'hFF, 8'hFE, 8'hFE, 8'h12, 8'h2C, 8'hFF, 8'h92};
    logic       tco [16] = '{0, 0, 0, 1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0};

    pipelined_ripple_adder #(.WIDTH(8), .STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout)
`ifdef RCA_PIPE_OVF_EN
        ,
        .Ovf       (Ovf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic v);
        A = a;
        B = b;
        Cin = c;
        in_valid = v;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (S !== 8'h00) begin
            errors++;
            $display("FAIL reset_s got %h want 00", S);
        end
        checks++;
        if (Cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_cout got %b want 0", Cout);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        step();
        drive(8'h3C, 8'h55, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic1_early got v=%b want v=0", out_valid);
        end
        step();
        checks++;
        if ({out_valid, Cout, S} !== {1'b1, 1'b0, 8'h91}) begin
            errors++;
            $display("FAIL basic1 got v=%b c=%b s=%h want v=1 c=0 s=91",
                     out_valid, Cout, S);
        end
        drive(8'hFF, 8'h00, 1'b1, 1'b1);
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic2_early got v=%b want v=0", out_valid);
        end
        step();
        checks++;
        if ({out_valid, Cout, S} !== {1'b1, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL basic2 got v=%b c=%b s=%h want v=1 c=1 s=00",
                     out_valid, Cout, S);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        step();
        drive(ta[0], tb_[0], tc[0], 1'b1);
        for (int k = 0; k <= 16; k++) begin
            step();
            if (k >= 1) begin
                checks++;
                if ({out_valid, Cout, S} !== {1'b1, tco[k-1], ts[k-1]}) begin
                    errors++;
                    $display("FAIL b2b[%0d] got v=%b c=%b s=%h want v=1 c=%b s=%h",
                             k-1, out_valid, Cout, S, tco[k-1], ts[k-1]);
                end
            end
            if (k + 1 < 16) begin
                drive(ta[k+1], tb_[k+1], tc[k+1], 1'b1);
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_backpressure();
        step();
        out_ready = 1'b1;
        drive(ta[8], tb_[8], tc[8], 1'b1);
        step();
        drive(ta[9], tb_[9], tc[9], 1'b1);
        for (int c = 3; c <= 6; c++) begin
            step();
            out_ready = 1'b0;
            drive(ta[10], tb_[10], tc[10], 1'b1);
            #1;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall_ready[%0d] got %b want 0", c, in_ready);
            end
            checks++;
            if ({out_valid, Cout, S} !== {1'b1, tco[8], ts[8]}) begin
                errors++;
                $display("FAIL bp_stall_hold[%0d] got v=%b c=%b s=%h want v=1 c=%b s=%h",
                         c, out_valid, Cout, S, tco[8], ts[8]);
            end
        end
        step();
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready got %b want 1", in_ready);
        end
        for (int k = 8; k <= 11; k++) begin
            checks++;
            if ({out_valid, Cout, S} !== {1'b1, tco[k], ts[k]}) begin
                errors++;
                $display("FAIL bp_out[%0d] got v=%b c=%b s=%h want v=1 c=%b s=%h",
                         k, out_valid, Cout, S, tco[k], ts[k]);
            end
            step();
            if (k == 8) begin
                drive(ta[11], tb_[11], tc[11], 1'b1);
            end else begin
                in_valid = 1'b0;
            end
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain got v=%b want v=0", out_valid);
        end
    endtask

    task automatic test_reset_midflight();
        step();
        drive(8'h10, 8'h20, 1'b0, 1'b1);
        step();
        drive(8'h30, 8'h01, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, Cout, S} !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL rst_async got v=%b r=%b c=%b s=%h want v=0 r=1 c=0 s=00",
                     out_valid, in_ready, Cout, S);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_ghost[%0d] got v=%b want v=0", k, out_valid);
            end
        end
        drive(8'h01, 8'h01, 1'b0, 1'b1);
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if ({out_valid, Cout, S} !== {1'b1, 1'b0, 8'h02}) begin
            errors++;
            $display("FAIL rst_after got v=%b c=%b s=%h want v=1 c=0 s=02",
                     out_valid, Cout, S);
        end
    endtask

`ifdef RCA_PIPE_OVF_EN
    task automatic test_ovf();
        logic [7:0] oa [3] = '{8'h7F, 8'h80, 8'hFF};
        logic [7:0] ob [3] = '{8'h01, 8'h80, 8'h01};
        logic [7:0] os [3] = '{8'h80, 8'h00, 8'h00};
        logic       oc [3] = '{1'b0, 1'b1, 1'b1};
        logic       ov [3] = '{1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            step();
            drive(oa[k], ob[k], 1'b0, 1'b1);
            step();
            in_valid = 1'b0;
            step();
            checks++;
            if ({out_valid, Cout, S, Ovf} !== {1'b1, oc[k], os[k], ov[k]}) begin
                errors++;
                $display("FAIL ovf[%0d] got v=%b c=%b s=%h o=%b want v=1 c=%b s=%h o=%b",
                         k, out_valid, Cout, S, Ovf, oc[k], os[k], ov[k]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
`ifdef RCA_PIPE_OVF_EN
        test_ovf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
